piso_serializer_tx: RTL
=======================

Name: piso_serializer_tx

Overview:
- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per enabled clock on `sout`.
- `sout_valid` and `frame_start` qualify each bit, so a downstream capture flipflop/deserializer samples `sout` only when `sout_valid`=1.
- It is the sending end of the single-bit serial link whose receiving end is a D-flipflop-based capture stage.

Parameters:
- WIDTH, 8, word length in bits (legal: WIDTH >= 2).
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
- load_valid  input  1  producer offers `din`.
- load_ready  output  1  serializer can accept a word this cycle.
- shift_en  input  1  bit-rate enable; while low in SHIFT, transmission pauses.
- sout  output  1  serial data bit.
- sout_valid  output  1  `sout` carries a valid bit this cycle.
- frame_start  output  1  high with the first bit of each word.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
  - While `rst_n`=0: state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, frame_start=0, busy=0.
  - Loads are ignored while `rst_n`=0.
  - Reset asserted mid-word aborts the word immediately. No partial word resumes after release.
- Counter and register widths:
  - Bit counter width is $clog2(WIDTH).
  - Shift register is WIDTH bits.
  - Last bit is reached when counter = WIDTH-1. There is no wrap past WIDTH-1.
- FSM, two states: IDLE and SHIFT.
  - IDLE:
    - load_ready=1, busy=0, sout_valid=0, frame_start=0, sout=0.
    - load_valid=1 at a rising edge: load shift register from din, counter:=0, go to SHIFT.
  - SHIFT:
    - busy=1.
    - sout = current head bit: shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
    - sout_valid = shift_en.
    - frame_start = shift_en AND (counter==0).
    - At an edge with shift_en=1 and counter<WIDTH-1: shift register advances one position toward the head; counter increments.
    - At an edge with shift_en=0: shift register, counter and state hold. The same bit is re-presented, with sout_valid=0.
    - At an edge with shift_en=1 and counter==WIDTH-1 (last bit):
      - load_valid=1: reload from din, counter:=0, stay in SHIFT (back-to-back, no gap cycle).
      - Otherwise: go to IDLE.
- load_ready (combinational) = rst_n AND (state==IDLE OR (state==SHIFT AND shift_en AND counter==WIDTH-1)).
  - An accept happens only when load_valid AND load_ready at a rising edge.
  - din is don't-care otherwise.
- Latency:
  - First bit appears on `sout` in the cycle after the accepting edge.
  - With shift_en held at 1, a word occupies exactly WIDTH consecutive cycles.
  - Continuous load_valid gives 100% link utilisation.
- Boundaries:
  - load_valid while busy and not on the last bit: not accepted. The producer must hold din/load_valid until the handshake.
  - shift_en low on the last bit: load_ready=0 until shift_en returns.
  - shift_en is ignored in IDLE.

Test Plan:
- Reset check: assert rst_n=0 mid-simulation, including asynchronously between clock edges -> all outputs 0 immediately; load_ready=1 after release.
- Single word (WIDTH=8, MSB_FIRST=1, shift_en=1): load din=8'hA5 -> sout=1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - sout_valid=1 for exactly those 8 cycles.
  - frame_start=1 only on the first.
  - busy falls after bit 8; load_ready=1 in IDLE.
- LSB-first (MSB_FIRST=0): din=8'h01 -> sout=1,0,0,0,0,0,0,0.
- Back-to-back: load_valid held high with din=8'hFF then 8'h00 -> 16 contiguous valid bits (8 ones, 8 zeros).
  - frame_start pulses at bits 1 and 9.
  - load_ready=1 only in the IDLE cycle and on bit 8.
- Stall: din=8'hC3, shift_en low for 3 cycles after bit 2 -> sout holds bit 3's value with sout_valid=0 for 3 cycles; the remaining bits resume intact, 8 valid bits total.
- Abort: rst_n pulsed low after bit 4 of 8'hF0, then a new load of 8'h0F -> no further F0 bits; 0F transmits fully and correctly.

Source files
------------

// File: rtl/piso_serializer_tx.sv
// Parallel-in/serial-out transmitter. A WIDTH-bit word is taken through a
// valid/ready handshake and sent one bit per enabled clock on sout, with
// sout_valid/frame_start qualifying each bit for the capture stage downstream.
//
// Handshake: a word is accepted exactly when load_valid && load_ready at a
// rising clk edge. load_ready is combinational and never depends on
// load_valid. The producer holds din/load_valid stable until that edge.
// After a handshake, din is don't-care.
module piso_serializer_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             last_bit;
  logic             head_bit;
  logic             accept;
  logic [WIDTH-1:0] shreg_adv;

  // Head bit and the register advanced one position toward the head.
  always_comb begin
    last_bit  = (cnt_q == LAST_IDX);
    head_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    shreg_adv = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                          : {1'b0, shreg_q[WIDTH-1:1]};
  end

  // Next-state and output logic; outputs are zero in IDLE.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    load_ready  = 1'b0;
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = rst_n;
        accept     = load_valid && load_ready;
        if (accept) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy        = 1'b1;
        sout        = head_bit;
        sout_valid  = shift_en;
        frame_start = shift_en && (cnt_q == '0);
        // Only the last bit can overlap with accepting the next word.
        load_ready  = rst_n && shift_en && last_bit;
        accept      = load_valid && load_ready;
        if (shift_en) begin
          if (!last_bit) begin
            shreg_d = shreg_adv;
            cnt_d   = cnt_q + CW'(1);
          end else if (accept) begin
            shreg_d = din;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shift register and bit counter; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

endmodule
